ldst_replay_unit: RTL and testbench
===================================

// Module: ldst_replay_unit
// PURPOSE
// Multi-bank L1 load/store unit for one MP; successor to the single-bank ldst path.
// Accepts one warp request (per-SP addr/data + active mask) and serves every bank in parallel each cycle.
// Bank conflicts are replayed internally until the mask drains; all lanes are returned in one response.
// Sits between the SP operand stage and writeback; global-scheduler fill port is optional.
// PARAMETERS
// DATA_WIDTH  32  L1 word width
// ADDR_WIDTH  10  word address width; low BANK_WIDTH bits select the bank
// SP_PER_MP   8   lanes per request
// NUM_BANKS   8   L1 banks; power of two, >=2
// BANK_WIDTH  $clog2(NUM_BANKS)  derived, do not override
// PORTS
// clk          in   1                   clock, rising edge
// rst_n        in   1                   async active-low reset
// req_valid    in   1                   request valid
// req_ready    out  1                   unit idle, can accept
// req_st       in   1                   1=store, 0=load
// req_mask     in   SP_PER_MP           active lanes
// req_addrs    in   [SP_PER_MP][ADDR_WIDTH]  per-lane word address
// req_datas    in   [SP_PER_MP][DATA_WIDTH]  per-lane store data
// resp_valid   out  1                   response valid, held until resp_ready
// resp_ready   in   1                   consumer accepts response
// resp_data    out  [SP_PER_MP][DATA_WIDTH]  load data per lane (0 for inactive lanes/stores)
// resp_mask    out  SP_PER_MP           copy of accepted req_mask
// replay_cnt   out  $clog2(SP_PER_MP)+1 access cycles used by last request
// busy         out  1                   FSM not in IDLE
// gs_we/gs_addr/gs_data  in  1/ADDR_WIDTH/DATA_WIDTH  fill port (LDST_GS_WRITE_EN only)
// BEHAVIOUR
// Reset: FSM=IDLE; req_ready=1; resp_valid=0, busy=0, resp_data/resp_mask/replay_cnt=0; BRAM contents undefined.
// FSM IDLE->ACCESS on req_valid&req_ready; request captured (addrs, datas, mask->rem_mask, st).
// ACCESS, per bank b each cycle: winner = lowest-index lane in rem_mask with addr[BANK_WIDTH-1:0]==b.
//  All rem_mask lanes with full address == winner's are served that cycle (broadcast); cleared from rem_mask.
//  Load: BRAM read issued; data 1 cycle later, written into resp_data of lanes served (delayed served mask).
//  Store: winner's data written; other same-address lanes retire without writing (lowest lane wins).
//  replay_cnt increments once per ACCESS cycle, saturating.
// ACCESS->DRAIN when rem_mask becomes 0 this cycle; DRAIN (1 cycle) captures final load data -> RESP.
// Empty req_mask: IDLE->RESP directly, replay_cnt=0, resp_data=0.
// RESP: resp_valid=1; on resp_ready ->IDLE, req_ready=1 same cycle as IDLE entry (no back-to-back in RESP).
// Latency: request accepted cycle N, resp_valid at N+k+2, k = max lanes mapping to one distinct-address set per bank.
// Best case (conflict-free) k=1 -> 3 cycles; worst (all lanes same bank, distinct addr) k=SP_PER_MP.
// BRAM read-during-write same address returns OLD data.
// rst_n asserted mid-operation: request dropped, outputs to reset values, no partial response.
// CONFIGURATION
// LDST_GS_WRITE_EN defined: gs_* ports exist; gs_we writes bank gs_addr[BANK_WIDTH-1:0] with priority.
//  In ACCESS, a store winner on that bank is not served that cycle (stays in rem_mask); loads unaffected.
// Not defined: gs_* ports absent; all BRAM writes come from stores only.
// STRUCTURE
// ldst_pkg: ldst_state_e {IDLE,ACCESS,DRAIN,RESP}, bank_of()/row_of() address split functions.
// Sub-module ldst_bank_arb (one per bank): rem_mask+addrs -> winner idx, served mask, valid.
// Reuse bram_1_1 per bank (depth 2**(ADDR_WIDTH-BANK_WIDTH)) and mux_generic for addr/data select.
// TESTING
// Load, lanes 0..7 addr 0..7 (one per bank) -> resp at accept+3, replay_cnt=1, data per preloaded values.
// Load, all lanes addr 8*i (all bank 0) -> replay_cnt=8, lane i gets mem[8*i], resp at accept+10.
// Load, all lanes addr 5 -> broadcast, replay_cnt=1, all lanes return mem[5].
// Store lanes 0,3 addr 12 data 0xA/0xB, then load addr 12 -> 0xA; req_mask=0 -> resp next cycle, cnt=0.
// rst_n pulled low during ACCESS -> resp_valid=0, req_ready=1 after release; next request completes normally.
// LDST_GS_WRITE_EN: gs_we to bank 2 while store targets bank 2 -> store replays one extra cycle, both writes land.

Source files
------------

// File: rtl/ldst_pkg.sv
// Shared types and address-split helpers for the multi-bank load/store replay unit.
package ldst_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} ldst_state_e;

   // Low bw address bits select the bank; the rest select the row within it.
   function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bw);
      return addr & ((32'd1 << bw) - 32'd1);
   endfunction

   function automatic logic [31:0] row_of(input logic [31:0] addr, input int bw);
      return addr >> bw;
   endfunction

endpackage

// File: rtl/bram_1_1.sv
// One write port, one registered read port; a same-address read during a write returns the old word.
module bram_1_1 #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 128,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ldst_bank_arb.sv
// Per-bank arbiter: picks the lowest pending lane on this bank and every pending lane sharing its address.
module ldst_bank_arb
   import ldst_pkg::*;
#(
   parameter  int SP_PER_MP  = 8,
   parameter  int ADDR_WIDTH = 10,
   parameter  int BANK_WIDTH = 3,
   parameter  int BANK       = 0,
   localparam int IDX_W      = (SP_PER_MP > 1) ? $clog2(SP_PER_MP) : 1
) (
   input  logic [SP_PER_MP-1:0]                 rem_mask,
   input  logic [SP_PER_MP-1:0][ADDR_WIDTH-1:0] addrs,
   output logic [IDX_W-1:0]                     win_idx,
   output logic [SP_PER_MP-1:0]                 served,
   output logic                                 valid
);

   always_comb begin
      win_idx = '0;
      valid   = 1'b0;
      served  = '0;
      // Descending scan so the last hit left standing is the lowest lane.
      for (int i = SP_PER_MP - 1; i >= 0; i--) begin
         if (rem_mask[i] &&
             BANK_WIDTH'(bank_of(32'(addrs[i]), BANK_WIDTH)) == BANK_WIDTH'(BANK)) begin
            win_idx = IDX_W'(i);
            valid   = 1'b1;
         end
      end
      for (int i = 0; i < SP_PER_MP; i++)
         served[i] = valid && rem_mask[i] && (addrs[i] == addrs[win_idx]);
   end

endmodule

// File: rtl/mux_generic.sv
// N-way selector over a packed array of WIDTH-bit entries.
module mux_generic #(
   parameter  int WIDTH = 32,
   parameter  int N     = 8,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0][WIDTH-1:0] din,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        dout
);

   assign dout = din[sel];

endmodule

// File: rtl/ldst_replay_unit.sv
// Multi-bank L1 load/store unit with internal bank-conflict replay.
// Optional global-scheduler fill port enabled by defining LDST_GS_WRITE_EN.
module ldst_replay_unit
   import ldst_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int ADDR_WIDTH = 10,
   parameter  int SP_PER_MP  = 8,
   parameter  int NUM_BANKS  = 8,
   localparam int BANK_WIDTH = $clog2(NUM_BANKS),
   localparam int ROW_W      = ADDR_WIDTH - BANK_WIDTH,
   localparam int CNT_W      = $clog2(SP_PER_MP) + 1,
   localparam int IDX_W      = (SP_PER_MP > 1) ? $clog2(SP_PER_MP) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 req_valid,
   output logic                                 req_ready,
   input  logic                                 req_st,
   input  logic [SP_PER_MP-1:0]                 req_mask,
   input  logic [SP_PER_MP-1:0][ADDR_WIDTH-1:0] req_addrs,
   input  logic [SP_PER_MP-1:0][DATA_WIDTH-1:0] req_datas,
   output logic                                 resp_valid,
   input  logic                                 resp_ready,
   output logic [SP_PER_MP-1:0][DATA_WIDTH-1:0] resp_data,
   output logic [SP_PER_MP-1:0]                 resp_mask,
   output logic [CNT_W-1:0]                     replay_cnt,
`ifdef LDST_GS_WRITE_EN
   input  logic                                 gs_we,
   input  logic [ADDR_WIDTH-1:0]                gs_addr,
   input  logic [DATA_WIDTH-1:0]                gs_data,
`endif
   output logic                                 busy
);

   ldst_state_e state_q, state_d;

   logic [SP_PER_MP-1:0][ADDR_WIDTH-1:0] addrs_q;
   logic [SP_PER_MP-1:0][DATA_WIDTH-1:0] datas_q;
   logic [SP_PER_MP-1:0]                 rem_mask, rem_next, served_all;
   logic                                 st_q;
   logic                                 acc;

   logic [NUM_BANKS-1:0][IDX_W-1:0]      win_idx;
   logic [NUM_BANKS-1:0]                 arb_valid, gs_hit, stall, serve_ok, bank_we;
   logic [NUM_BANKS-1:0][SP_PER_MP-1:0]  served_raw, served_b, ld_pipe;
   logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] win_addr;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] win_data, rdata;

   assign acc = (state_q == ACCESS);

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [ROW_W-1:0]      waddr;
      logic [DATA_WIDTH-1:0] wdata;

      ldst_bank_arb #(
         .SP_PER_MP (SP_PER_MP),
         .ADDR_WIDTH(ADDR_WIDTH),
         .BANK_WIDTH(BANK_WIDTH),
         .BANK      (b)
      ) u_arb (
         .rem_mask(rem_mask),
         .addrs   (addrs_q),
         .win_idx (win_idx[b]),
         .served  (served_raw[b]),
         .valid   (arb_valid[b])
      );

      mux_generic #(.WIDTH(ADDR_WIDTH), .N(SP_PER_MP)) u_amux (
         .din(addrs_q), .sel(win_idx[b]), .dout(win_addr[b])
      );

      mux_generic #(.WIDTH(DATA_WIDTH), .N(SP_PER_MP)) u_dmux (
         .din(datas_q), .sel(win_idx[b]), .dout(win_data[b])
      );

`ifdef LDST_GS_WRITE_EN
      // Fill writes own the bank write port; a colliding store waits a cycle.
      assign gs_hit[b] = gs_we &&
                         (BANK_WIDTH'(bank_of(32'(gs_addr), BANK_WIDTH)) == BANK_WIDTH'(b));
      assign waddr = gs_hit[b] ? ROW_W'(row_of(32'(gs_addr), BANK_WIDTH))
                               : ROW_W'(row_of(32'(win_addr[b]), BANK_WIDTH));
      assign wdata = gs_hit[b] ? gs_data : win_data[b];
`else
      assign gs_hit[b] = 1'b0;
      assign waddr     = ROW_W'(row_of(32'(win_addr[b]), BANK_WIDTH));
      assign wdata     = win_data[b];
`endif

      assign stall[b]    = gs_hit[b] && st_q;
      assign serve_ok[b] = acc && arb_valid[b] && !stall[b];
      assign served_b[b] = serve_ok[b] ? served_raw[b] : '0;
      assign bank_we[b]  = gs_hit[b] || (serve_ok[b] && st_q);

      bram_1_1 #(.WIDTH(DATA_WIDTH), .DEPTH(2 ** ROW_W)) u_bram (
         .clk  (clk),
         .we   (bank_we[b]),
         .waddr(waddr),
         .wdata(wdata),
         .re   (serve_ok[b] && !st_q),
         .raddr(ROW_W'(row_of(32'(win_addr[b]), BANK_WIDTH))),
         .rdata(rdata[b])
      );
   end

   always_comb begin
      served_all = '0;
      for (int b = 0; b < NUM_BANKS; b++) served_all = served_all | served_b[b];
      rem_next = rem_mask & ~served_all;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = (req_mask == '0) ? RESP : ACCESS;
         ACCESS:  if (rem_next == '0) state_d = DRAIN;
         DRAIN:   state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addrs_q    <= '0;
         datas_q    <= '0;
         rem_mask   <= '0;
         st_q       <= 1'b0;
         resp_mask  <= '0;
         resp_data  <= '0;
         replay_cnt <= '0;
         ld_pipe    <= '0;
      end else if (state_q == IDLE && req_valid) begin
         addrs_q    <= req_addrs;
         datas_q    <= req_datas;
         rem_mask   <= req_mask;
         st_q       <= req_st;
         resp_mask  <= req_mask;
         resp_data  <= '0;
         replay_cnt <= '0;
         ld_pipe    <= '0;
      end else begin
         if (acc) begin
            rem_mask <= rem_next;
            if (replay_cnt != '1) replay_cnt <= replay_cnt + 1'b1;
         end
         // Read data lands one cycle after issue, steered by the delayed served mask.
         for (int b = 0; b < NUM_BANKS; b++) begin
            ld_pipe[b] <= (serve_ok[b] && !st_q) ? served_b[b] : '0;
            for (int l = 0; l < SP_PER_MP; l++)
               if (ld_pipe[b][l]) resp_data[l] <= rdata[b];
         end
      end
   end

endmodule

// File: tb/tb_ldst_replay_unit.sv
// Scoreboard bench for ldst_replay_unit: expected responses queued at issue, checked on handshake.
module tb_ldst_replay_unit;

   localparam int DW = 32, AW = 10, SP = 8, NB = 8, CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic                  req_valid = 1'b0, req_st = 1'b0, resp_ready = 1'b1;
   logic [SP-1:0]         req_mask = '0;
   logic [SP-1:0][AW-1:0] req_addrs = '0;
   logic [SP-1:0][DW-1:0] req_datas = '0;
   logic                  req_ready, resp_valid, busy;
   logic [SP-1:0][DW-1:0] resp_data;
   logic [SP-1:0]         resp_mask;
   logic [CW-1:0]         replay_cnt;
`ifdef LDST_GS_WRITE_EN
   logic                  gs_we = 1'b0;
   logic [AW-1:0]         gs_addr = '0;
   logic [DW-1:0]         gs_data = '0;
`endif

   ldst_replay_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_st    (req_st),
      .req_mask  (req_mask),
      .req_addrs (req_addrs),
      .req_datas (req_datas),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_data (resp_data),
      .resp_mask (resp_mask),
      .replay_cnt(replay_cnt),
`ifdef LDST_GS_WRITE_EN
      .gs_we     (gs_we),
      .gs_addr   (gs_addr),
      .gs_data   (gs_data),
`endif
      .busy      (busy)
   );

   typedef struct {
      logic [SP-1:0][DW-1:0] data;
      logic [SP-1:0]         mask;
      int                    cnt;
      int                    lat;
      int                    acc;
   } exp_t;

   exp_t       sbq[$];
   exp_t       mon_e;
   logic [DW-1:0] mem [1024];
   int         n_chk = 0, n_pass = 0, cyc = 0;
   bit         seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (!rst_n) seen = 1'b0;
      else if (resp_valid) begin
         if (sbq.size() == 0) check("resp_without_req", 64'(sbq.size()), 64'd1);
         else begin
            mon_e = sbq[0];
            if (!seen) begin
               check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
               check("busy_resp", 64'(busy), 64'd1);
               seen = 1'b1;
            end
            if (resp_ready) begin
               check("replay_cnt", 64'(replay_cnt), 64'(mon_e.cnt));
               check("resp_mask", 64'(resp_mask), 64'(mon_e.mask));
               for (int l = 0; l < SP; l++)
                  check($sformatf("lane%0d_data", l), 64'(resp_data[l]), 64'(mon_e.data[l]));
               void'(sbq.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // Expected cycles = most distinct addresses any single bank must serve.
   task automatic send(input logic st, input logic [SP-1:0] m,
                       input logic [SP-1:0][AW-1:0] a, input logic [SP-1:0][DW-1:0] d,
                       input int xtra);
      exp_t e;
      int k, nd, t;
      bit dup;
      k = 0;
      for (int b = 0; b < NB; b++) begin
         nd = 0;
         for (int i = 0; i < SP; i++) begin
            if (m[i] && int'(a[i][2:0]) == b) begin
               dup = 1'b0;
               for (int j = 0; j < i; j++) if (m[j] && a[j] == a[i]) dup = 1'b1;
               if (!dup) nd++;
            end
         end
         if (nd > k) k = nd;
      end
      e.cnt  = (m == '0) ? 0 : k + xtra;
      e.lat  = (m == '0) ? 1 : e.cnt + 2;
      e.mask = m;
      for (int i = 0; i < SP; i++) e.data[i] = (!st && m[i]) ? mem[a[i]] : '0;
      if (st) for (int i = SP - 1; i >= 0; i--) if (m[i]) mem[a[i]] = d[i];
      t = 0;
      while (!req_ready) begin
         @(posedge clk); #1;
         t++;
         if (t > 50) begin check("req_ready_timeout", 64'(req_ready), 64'd1); break; end
      end
      req_valid = 1'b1; req_st = st; req_mask = m; req_addrs = a; req_datas = d;
      e.acc = cyc;
      sbq.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      for (int t = 0; t < 60; t++) begin
         if (sbq.size() == 0) break;
         @(posedge clk); #1;
      end
      check("resp_timeout", 64'(sbq.size()), 64'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_cnt"}, 64'(replay_cnt), 64'd0);
      check({tag, "_mask"}, 64'(resp_mask), 64'd0);
      check({tag, "_data"}, 64'(|resp_data), 64'd0);
   endtask

   logic [SP-1:0][AW-1:0] a;
   logic [SP-1:0][DW-1:0] d;

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_idle("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("post_rst");

      for (int i = 0; i < SP; i++) begin a[i] = AW'(i); d[i] = 32'h100 + i; end
      send(1'b1, 8'hFF, a, d, 0); wait_resp();
      for (int i = 0; i < SP; i++) begin a[i] = AW'(8 * i); d[i] = 32'h200 + i; end
      send(1'b1, 8'hFF, a, d, 0); wait_resp();
      for (int i = 0; i < SP; i++) begin a[i] = AW'(12); d[i] = 32'hE0 + i; end
      d[0] = 32'hA; d[3] = 32'hB;
      send(1'b1, 8'b0000_1001, a, d, 0); wait_resp();

      d = '0;
      for (int i = 0; i < SP; i++) a[i] = AW'(i);
      send(1'b0, 8'hFF, a, d, 0); wait_resp();
      for (int i = 0; i < SP; i++) a[i] = AW'(8 * i);
      send(1'b0, 8'hFF, a, d, 0); wait_resp();
      for (int i = 0; i < SP; i++) a[i] = AW'(5);
      send(1'b0, 8'hFF, a, d, 0); wait_resp();
      for (int i = 0; i < SP; i++) a[i] = AW'(12);
      send(1'b0, 8'hFF, a, d, 0); wait_resp();
      send(1'b0, 8'h00, a, d, 0); wait_resp();

      // Consumer back-pressure: response must hold.
      for (int i = 0; i < SP; i++) a[i] = AW'(7 - i);
      send(1'b0, 8'hFF, a, d, 0);
      resp_ready = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      check("resp_held", 64'(resp_valid), 64'd1);
      resp_ready = 1'b1;
      wait_resp();

      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < SP; i++) begin
            case ($urandom_range(0, 2))
               0:       a[i] = AW'($urandom_range(0, 7));
               1:       a[i] = AW'(8 * $urandom_range(0, 7));
               default: a[i] = AW'(12);
            endcase
         end
         send(1'b0, SP'($urandom_range(0, 255)), a, d, 0); wait_resp();
      end

      // Reset in the middle of a long replay drops the request.
      for (int i = 0; i < SP; i++) a[i] = AW'(8 * i);
      send(1'b0, 8'hFF, a, d, 0);
      repeat (3) begin @(posedge clk); #1; end
      check("busy_mid", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1 sbq.delete();
      check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_mid_req_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("rst_mid");
      for (int i = 0; i < SP; i++) a[i] = AW'(i);
      send(1'b0, 8'hFF, a, d, 0); wait_resp();

`ifdef LDST_GS_WRITE_EN
      for (int i = 0; i < SP; i++) a[i] = AW'(10);
      d[0] = 32'hC0FFEE;
      send(1'b1, 8'h01, a, d, 1);
      gs_we = 1'b1; gs_addr = AW'(2); gs_data = 32'hBEEF; mem[2] = 32'hBEEF;
      @(posedge clk); #1 gs_we = 1'b0;
      wait_resp();
      d = '0; a[0] = AW'(2); a[1] = AW'(10);
      send(1'b0, 8'h03, a, d, 0); wait_resp();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
